// File: rtl/sound_clip_pkg.sv
// rtl/sound_clip_pkg.sv - clip table and state encoding for the sound clip player
package sound_clip_pkg;

  typedef enum logic [1:0] {CLIP_WIN, CLIP_MOO, CLIP_DETECT, CLIP_CHEER} clip_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PUSH, ST_HOLD} state_e;

  // Clips sit back-to-back in the shared sample ROM; bounds are inclusive.
  localparam int unsigned WIN_START    = 0;
  localparam int unsigned WIN_END      = 16395;
  localparam int unsigned MOO_START    = 16396;
  localparam int unsigned MOO_END      = 66982;
  localparam int unsigned DETECT_START = 66983;
  localparam int unsigned DETECT_END   = 83254;
  localparam int unsigned CHEER_START  = 83255;
  localparam int unsigned CHEER_END    = 137138;

  function automatic int unsigned clip_start(input clip_e c);
    case (c)
      CLIP_WIN:    clip_start = WIN_START;
      CLIP_MOO:    clip_start = MOO_START;
      CLIP_DETECT: clip_start = DETECT_START;
      default:     clip_start = CHEER_START;
    endcase
  endfunction

  function automatic int unsigned clip_end(input clip_e c);
    case (c)
      CLIP_WIN:    clip_end = WIN_END;
      CLIP_MOO:    clip_end = MOO_END;
      CLIP_DETECT: clip_end = DETECT_END;
      default:     clip_end = CHEER_END;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample-rate divider; tick marks the last cycle of each period
module sample_tick_gen #(
  parameter int DIV = 1200
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_top;

  assign at_top = (cnt == CNT_W'(DIV - 1));
  assign tick   = en && !clr && at_top;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_top ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sound_clip_player.sv
// rtl/sound_clip_player.sv - plays one of four ROM clips into the audio controller at the sample rate
module sound_clip_player
  import sound_clip_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int SAMPLE_W = 6,
  parameter int TICK_DIV = 1200,
  parameter int ROM_LAT  = 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [1:0]          clip_sel,
  input  logic                trigger,
  input  logic                stop,
  input  logic                loop_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [31:0]         left_channel_audio_out,
  output logic [31:0]         right_channel_audio_out,
  output logic                busy,
  output logic                done,
  output logic                late
);

  localparam int LAT_W = $clog2(ROM_LAT + 2);

  state_e              state, next_state;
  logic [ADDR_W-1:0]   clip_lo, clip_hi;
  logic [SAMPLE_W-1:0] sample;
  logic [LAT_W-1:0]    lat_cnt;
  logic                pending_tick;
  logic                tick;
  logic                fetch_ready, at_end, abort;
  logic                capture, hold_go, tick_late;

  sample_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .en      (busy),
    .clr     (trigger),
    .tick    (tick)
  );

  assign fetch_ready = (lat_cnt == LAT_W'(ROM_LAT));
  assign at_end      = (rom_addr == clip_hi);
  assign abort       = stop && (state != ST_IDLE);

  assign left_channel_audio_out  = {sample, {(32 - SAMPLE_W){1'b0}}};
  assign right_channel_audio_out = left_channel_audio_out;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Trigger outranks stop; stop only matters once a clip is active.
  always_comb begin
    next_state = state;
    if (trigger) begin
      next_state = ST_FETCH;
    end else if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  next_state = ST_IDLE;
        ST_FETCH: if (fetch_ready) next_state = ST_PUSH;
        ST_PUSH:  if (audio_out_allowed) next_state = ST_HOLD;
        ST_HOLD:  if (tick || pending_tick) next_state = (!at_end || loop_en) ? ST_FETCH : ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    write_audio_out = (state == ST_PUSH) && audio_out_allowed;
    capture         = (state == ST_FETCH) && fetch_ready;
    hold_go         = (state == ST_HOLD) && (tick || pending_tick);
    tick_late       = tick && ((state == ST_FETCH) || (state == ST_PUSH));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rom_addr     <= '0;
      clip_lo      <= '0;
      clip_hi      <= '0;
      sample       <= '0;
      lat_cnt      <= '0;
      pending_tick <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      late         <= 1'b0;
    end else begin
      done    <= 1'b0;
      lat_cnt <= (state == ST_FETCH && next_state == ST_FETCH && !trigger) ? lat_cnt + LAT_W'(1) : '0;
      if (trigger) begin
        clip_lo      <= ADDR_W'(clip_start(clip_e'(clip_sel)));
        clip_hi      <= ADDR_W'(clip_end(clip_e'(clip_sel)));
        rom_addr     <= ADDR_W'(clip_start(clip_e'(clip_sel)));
        busy         <= 1'b1;
        late         <= 1'b0;
        pending_tick <= 1'b0;
      end else if (abort) begin
        busy         <= 1'b0;
        sample       <= '0;
        pending_tick <= 1'b0;
      end else begin
        if (capture) sample <= rom_q;
        if (tick_late) begin
          pending_tick <= 1'b1;
          late         <= 1'b1;
        end
        if (hold_go) begin
          pending_tick <= 1'b0;
          if (!at_end) begin
            rom_addr <= rom_addr + ADDR_W'(1);
          end else if (loop_en) begin
            rom_addr <= clip_lo;
          end else begin
            done   <= 1'b1;
            busy   <= 1'b0;
            sample <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sound_clip_player.sv
// tb/tb_sound_clip_player.sv - self-checking bench for sound_clip_player
module tb_sound_clip_player;

  localparam int M_DIV       = 8;
  localparam int L_DIV       = 4;
  localparam int LAT         = 1;
  localparam int LONG_BUDGET = 70000;

  int unsigned clip_lo [4] = '{0, 16396, 66983, 83255};
  int unsigned clip_hi [4] = '{16395, 66982, 83254, 137138};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        m_resetn, m_trigger, m_stop, m_allowed;
  logic        m_loop_en = 1'b0;
  logic [1:0]  m_clip_sel;
  logic [17:0] m_rom_addr;
  logic [5:0]  m_rom_q = '0;
  logic        m_write, m_busy, m_done, m_late;
  logic [31:0] m_left, m_right;

  logic        l_resetn, lg_trigger;
  logic        lg_stop    = 1'b0;
  logic        lg_allowed = 1'b1;
  logic [1:0]  lg_clip_sel = 2'd0;
  logic        e_loop_en = 1'b0;
  logic        l_loop_en = 1'b1;
  logic [17:0] e_rom_addr, l_rom_addr;
  logic [5:0]  e_rom_q = '0, l_rom_q = '0;
  logic        e_write, e_busy, e_done, e_late, l_write, l_busy, l_done, l_late;
  logic [31:0] e_left, e_right, l_left, l_right;

  sound_clip_player #(.TICK_DIV(M_DIV), .ROM_LAT(LAT)) dut (
    .CLOCK_50(clk), .resetn(m_resetn), .clip_sel(m_clip_sel), .trigger(m_trigger),
    .stop(m_stop), .loop_en(m_loop_en), .rom_addr(m_rom_addr), .rom_q(m_rom_q),
    .audio_out_allowed(m_allowed), .write_audio_out(m_write),
    .left_channel_audio_out(m_left), .right_channel_audio_out(m_right),
    .busy(m_busy), .done(m_done), .late(m_late));

  sound_clip_player #(.TICK_DIV(L_DIV), .ROM_LAT(LAT)) dut_end (
    .CLOCK_50(clk), .resetn(l_resetn), .clip_sel(lg_clip_sel), .trigger(lg_trigger),
    .stop(lg_stop), .loop_en(e_loop_en), .rom_addr(e_rom_addr), .rom_q(e_rom_q),
    .audio_out_allowed(lg_allowed), .write_audio_out(e_write),
    .left_channel_audio_out(e_left), .right_channel_audio_out(e_right),
    .busy(e_busy), .done(e_done), .late(e_late));

  sound_clip_player #(.TICK_DIV(L_DIV), .ROM_LAT(LAT)) dut_loop (
    .CLOCK_50(clk), .resetn(l_resetn), .clip_sel(lg_clip_sel), .trigger(lg_trigger),
    .stop(lg_stop), .loop_en(l_loop_en), .rom_addr(l_rom_addr), .rom_q(l_rom_q),
    .audio_out_allowed(lg_allowed), .write_audio_out(l_write),
    .left_channel_audio_out(l_left), .right_channel_audio_out(l_right),
    .busy(l_busy), .done(l_done), .late(l_late));

  // One-cycle synchronous ROM whose contents are the low address bits.
  always @(posedge clk) begin
    m_rom_q <= m_rom_addr[5:0];
    e_rom_q <= e_rom_addr[5:0];
    l_rom_q <= l_rom_addr[5:0];
  end

  // Whole-clip observers for the two long-running players.
  int unsigned e_exp = 0, l_exp = 0;
  int e_writes = 0, e_seq_err = 0, e_done_cnt = 0, e_after = 0;
  int l_writes = 0, l_seq_err = 0, l_done_cnt = 0;
  bit l_wrap_seen = 1'b0;

  always @(negedge clk) begin
    if (e_done) e_done_cnt <= e_done_cnt + 1;
    if (e_write) begin
      if (e_done_cnt > 0) e_after <= e_after + 1;
      if (e_rom_addr != e_exp[17:0] || e_left != {e_exp[5:0], 26'b0} || e_right != e_left)
        e_seq_err <= e_seq_err + 1;
      e_exp    <= (e_exp == clip_hi[0]) ? clip_lo[0] : e_exp + 1;
      e_writes <= e_writes + 1;
    end
    if (l_done) l_done_cnt <= l_done_cnt + 1;
    if (l_write) begin
      if (l_rom_addr == 18'd0 && l_writes > 0) l_wrap_seen <= 1'b1;
      if (l_rom_addr != l_exp[17:0] || l_left != {l_exp[5:0], 26'b0} || l_right != l_left)
        l_seq_err <= l_seq_err + 1;
      l_exp    <= (l_exp == clip_hi[0]) ? clip_lo[0] : l_exp + 1;
      l_writes <= l_writes + 1;
    end
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  int m_wr_cnt = 0, m_done_cnt = 0;
  logic        s_write, s_busy, s_done, s_late;
  logic [17:0] s_addr;
  logic [31:0] s_left, s_right;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample the main player mid-cycle, then step to just after the next edge.
  task automatic tick();
    @(negedge clk);
    s_write = m_write; s_addr = m_rom_addr; s_left = m_left; s_right = m_right;
    s_busy = m_busy; s_done = m_done; s_late = m_late;
    if (m_write) m_wr_cnt++;
    if (m_done) m_done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input int c);
    m_clip_sel = 2'(c);
    m_trigger  = 1'b1;
    tick();
    m_trigger  = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_write && n < budget);
    chk({tag, "_seen"}, s_write, 1);
  endtask

  task automatic check_write(input string tag, input int unsigned a);
    logic [31:0] w;
    w = {a[5:0], 26'b0};
    chk({tag, "_addr"}, s_addr, a);
    chk({tag, "_left"}, s_left, w);
    chk({tag, "_right"}, s_right, w);
  endtask

  initial begin
    int n, nw, stall, c1, c2, d0, w0;
    int unsigned exp;
    m_resetn = 1'b0; l_resetn = 1'b0; m_trigger = 1'b0; lg_trigger = 1'b0;
    m_stop = 1'b0; m_allowed = 1'b0; m_clip_sel = 2'd0;
    repeat (3) tick();
    chk("rst_addr", s_addr, 0);
    chk("rst_write", s_write, 0);
    chk("rst_left", s_left, 0);
    chk("rst_right", s_right, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_late", s_late, 0);

    m_resetn = 1'b1; l_resetn = 1'b1;
    tick();
    lg_trigger = 1'b1;
    tick();
    lg_trigger = 1'b0;

    m_stop = 1'b1;
    tick();
    m_stop = 1'b0;
    repeat (4) tick();
    chk("idle_busy", s_busy, 0);
    chk("idle_writes", m_wr_cnt, 0);
    chk("idle_addr", s_addr, 0);

    m_allowed = 1'b1;
    pulse_trigger(2);
    exp = clip_lo[2];
    wait_write("first", 4 * M_DIV, n);
    chk("first_latency_min", n >= LAT + 1, 1);
    check_write("first", exp);
    nw = $urandom_range(3, 6);
    for (int i = 0; i < nw; i++) begin
      exp++;
      wait_write("steady", 4 * M_DIV, n);
      chk("steady_period", n, M_DIV);
      check_write("steady", exp);
    end
    chk("steady_late", s_late, 0);

    stall = $urandom_range(20, 28);
    m_allowed = 1'b0;
    w0 = m_wr_cnt;
    repeat (stall) tick();
    chk("stall_no_write", m_wr_cnt, w0);
    chk("stall_late", s_late, 1);
    chk("stall_busy", s_busy, 1);
    m_allowed = 1'b1;
    tick();
    exp++;
    chk("resume_immediate", s_write, 1);
    check_write("resume", exp);
    for (int i = 0; i < 2; i++) begin
      exp++;
      wait_write("post_stall", 4 * M_DIV, n);
      check_write("post_stall", exp);
      chk("late_sticky", s_late, 1);
    end

    d0 = m_done_cnt;
    pulse_trigger(1);
    tick();
    chk("late_cleared", s_late, 0);
    exp = clip_lo[1];
    wait_write("moo_first", 4 * M_DIV, n);
    check_write("moo_first", exp);
    nw = $urandom_range(1, 3);
    for (int i = 0; i < nw; i++) begin
      exp++;
      wait_write("moo", 4 * M_DIV, n);
      check_write("moo", exp);
    end
    repeat ($urandom_range(0, M_DIV - 1)) tick();
    pulse_trigger(3);
    wait_write("cheer_first", 4 * M_DIV, n);
    check_write("cheer_first", clip_lo[3]);
    chk("retrig_no_done", m_done_cnt, d0);

    repeat ($urandom_range(1, M_DIV)) tick();
    m_stop = 1'b1;
    tick();
    m_stop = 1'b0;
    tick();
    chk("stop_busy", s_busy, 0);
    chk("stop_left", s_left, 0);
    chk("stop_right", s_right, 0);
    w0 = m_wr_cnt;
    repeat (3 * M_DIV) tick();
    chk("stop_quiet", m_wr_cnt, w0);
    chk("stop_no_done", m_done_cnt, d0);

    c1 = $urandom_range(0, 3);
    pulse_trigger(c1);
    wait_write("pre_combo", 4 * M_DIV, n);
    check_write("pre_combo", clip_lo[c1]);
    c2 = $urandom_range(0, 3);
    m_stop = 1'b1;
    pulse_trigger(c2);
    m_stop = 1'b0;
    tick();
    chk("combo_busy", s_busy, 1);
    wait_write("combo", 4 * M_DIV, n);
    check_write("combo", clip_lo[c2]);

    m_allowed = 1'b0;
    c1 = $urandom_range(1, 3);
    pulse_trigger(c1);
    repeat (6) tick();
    chk("push_busy", s_busy, 1);
    chk("push_left", s_left, {clip_lo[c1][5:0], 26'b0});
    w0 = m_wr_cnt;
    m_allowed = 1'b1;
    m_resetn  = 1'b0;
    #1;
    chk("arst_addr", m_rom_addr, 0);
    chk("arst_write", m_write, 0);
    chk("arst_left", m_left, 0);
    chk("arst_right", m_right, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_done", m_done, 0);
    chk("arst_late", m_late, 0);
    tick();
    tick();
    m_resetn = 1'b1;
    repeat (4 * M_DIV) tick();
    chk("post_rst_writes", m_wr_cnt, w0);
    chk("post_rst_busy", s_busy, 0);
    chk("post_rst_addr", s_addr, 0);

    for (int i = 0; i < LONG_BUDGET && !(e_done_cnt > 0 && l_wrap_seen); i++) tick();
    chk("long_finished", (e_done_cnt > 0) && l_wrap_seen, 1);
    repeat (4 * L_DIV) tick();
    chk("end_writes", e_writes, clip_hi[0] - clip_lo[0] + 1);
    chk("end_sequence", e_seq_err, 0);
    chk("end_done_once", e_done_cnt, 1);
    chk("end_no_more", e_after, 0);
    chk("end_busy", e_busy, 0);
    chk("loop_sequence", l_seq_err, 0);
    chk("loop_no_done", l_done_cnt, 0);
    chk("loop_busy", l_busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
